dmem_stage_ws: RTL

//  Parametrised data-memory stage for the MIPS pipeline: synchronous word RAM with byte/half/word

---
 rtl/dmem_stage_ws.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_stage_ws.sv
// dmem_stage_ws: MIPS data-memory stage. Word RAM with byte/half/word loads
// and stores, sign/zero extension and WAIT_CYC wait states per access.
// MEM_busy stalls the pipeline while a request is in flight.
// Optional build macro: DMEM_ALIGN_CHECK_EN flags misaligned half/word
// accesses as errors; otherwise the offending low address bits are forced to 0.
`timescale 1ns/1ps
module dmem_stage_ws #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_req,
  input  logic        MEM_we,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_unsigned,
  input  logic [31:0] ALU_MEM_addr,
  input  logic [31:0] MEM_datain,
  output logic [31:0] MEM_dout,
  output logic        MEM_ready,
  output logic        MEM_busy,
  output logic        MEM_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : '0;

  state_t             state, state_nxt;
  logic [3:0]         wcnt;
  logic               we_q, uns_q;
  logic [1:0]         size_q;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        din_q;

  logic [31:0]        mem [0:(1<<ADDR_W)-1];

  logic               accept, do_access, acc_err;
  logic [1:0]         off;
  logic [4:0]         sh;
  logic [31:0]        lane_mask, rd_word, wr_word, ld_sh, ld_val;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^ALU_MEM_addr[31:ADDR_W+2];
  assign accept    = (state == S_IDLE) && MEM_req;
  assign do_access = (state == S_ACCESS);
  assign MEM_busy  = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> [WAIT x WAIT_CYC] -> ACCESS -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (MEM_req) state_nxt = (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (wcnt == WAIT_LAST) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Wait-state counter, cleared whenever not waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wcnt <= '0;
    else if (state == S_WAIT) wcnt <= wcnt + 4'd1;
    else                     wcnt <= '0;
  end

  // Request capture; inputs are ignored once the access is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      din_q  <= '0;
    end else if (accept) begin
      we_q   <= MEM_we;
      uns_q  <= MEM_unsigned;
      size_q <= MEM_size;
      addr_q <= ALU_MEM_addr[ADDR_W+1:0];
      din_q  <= MEM_datain;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign acc_err  = (size_q == 2'b11) || misalign;
`else
  assign acc_err  = (size_q == 2'b11);
`endif

  // Lane selection, store merge and load extension for the captured request.
  // Misaligned offsets are forced down; in the checking build they never
  // reach memory or MEM_dout because acc_err blocks them.
  always_comb begin
    off       = addr_q[1:0];
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: lane_mask = 32'h0000_00FF;
      2'b01: begin lane_mask = 32'h0000_FFFF; off = {addr_q[1], 1'b0}; end
      default: off = 2'b00;
    endcase
    sh      = {off, 3'b000};
    rd_word = mem[addr_q[ADDR_W+1:2]];
    wr_word = (rd_word & ~(lane_mask << sh)) | ((din_q & lane_mask) << sh);
    ld_sh   = rd_word >> sh;
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, ld_sh[7:0]}  : {{24{ld_sh[7]}}, ld_sh[7:0]};
      2'b01:   ld_val = uns_q ? {16'h0, ld_sh[15:0]} : {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // RAM write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (do_access && we_q && !acc_err) mem[addr_q[ADDR_W+1:2]] <= wr_word;
  end

  // Completion pulses and load result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEM_ready <= 1'b0;
      MEM_err   <= 1'b0;
      MEM_dout  <= '0;
    end else begin
      MEM_ready <= do_access;
      MEM_err   <= do_access && acc_err;
      if (do_access && !we_q && !acc_err) MEM_dout <= ld_val;
    end
  end

endmodule
